// File: rtl/fpu_dispatcher_pkg.sv
// Shared definitions for the fixed-point unit dispatcher: operation codes,
// FSM state encoding and saturating counter helpers.
package fpu_dispatcher_pkg;

  // Operation codes understood by the fixed-point unit.
  typedef enum logic [1:0] {
    FPU_ADD  = 2'b00,
    FPU_SUB  = 2'b01,
    FPU_MUL  = 2'b10,
    FPU_SQRT = 2'b11
  } fpu_op_e;

  // Dispatcher FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Width of the wait/timeout counter (TIMEOUT is limited to 255).
  localparam int CNT_W = 8;

  // Increment a 16-bit statistics counter, sticking at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

  // Increment an 8-bit statistics counter, sticking at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/fpu_timeout_counter.sv
// Wait-cycle counter for the dispatcher. Counts cycles spent waiting on the
// fixed-point unit, flags the first waiting cycle (stale-ready guard) and the
// last cycle before the dispatcher gives up with an error response.
module fpu_timeout_counter
  import fpu_dispatcher_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic at_zero,
  output logic terminal
);

  localparam logic [CNT_W-1:0] TERM_COUNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_r;

  // Clear while idle, advance once per waiting cycle, otherwise hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign at_zero  = (count_r == {CNT_W{1'b0}});
  assign terminal = (count_r == TERM_COUNT);

endmodule

// File: rtl/fpu_dispatcher.sv
// Single-outstanding-request dispatcher in front of a fixed-point unit.
// Accepts one request, holds its operands on the unit's inputs, waits for the
// unit's ready (or times out), then presents a response until handshaked.
module fpu_dispatcher
  import fpu_dispatcher_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FBITS   = 10,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] fpu_operand_1,
  output logic [WIDTH-1:0] fpu_operand_2,
  output logic [1:0]       fpu_operation,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_error,
  output logic             busy,
  output logic [15:0]      ops_done,
  output logic [7:0]       err_count
);

  // FBITS only documents the Q format of the operands; an impossible value
  // leaves an empty, named marker block in the elaborated hierarchy.
  if (FBITS >= WIDTH) begin : g_fbits_exceeds_width
  end

  state_e           state_r;
  fpu_op_e          op_r;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH-1:0] res_r;
  logic             err_r;
  logic [15:0]      ops_done_r;
  logic [7:0]       err_count_r;

  logic             cnt_clear_s;
  logic             cnt_en_s;
  logic             cnt_zero_s;
  logic             cnt_term_s;

  // Counter is held at zero while idle so every request starts from a clean count.
  always_comb begin
    cnt_clear_s = 1'b0;
    cnt_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_clear_s = 1'b1;
        cnt_en_s    = 1'b0;
      end
      ST_WAIT: begin
        cnt_clear_s = 1'b0;
        cnt_en_s    = 1'b1;
      end
      default: begin
        cnt_clear_s = 1'b0;
        cnt_en_s    = 1'b0;
      end
    endcase
  end

  fpu_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear_s),
    .enable   (cnt_en_s),
    .at_zero  (cnt_zero_s),
    .terminal (cnt_term_s)
  );

  // Dispatcher FSM with all datapath and statistics registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      op_r        <= FPU_ADD;
      opa_r       <= '0;
      opb_r       <= '0;
      res_r       <= '0;
      err_r       <= 1'b0;
      ops_done_r  <= 16'd0;
      err_count_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            op_r    <= fpu_op_e'(req_op);
            opa_r   <= req_a;
            opb_r   <= req_b;
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // A ready seen in the first waiting cycle may belong to the previous
          // operation, so it is only trusted once the counter has moved.
          // Success is checked first so a late ready still wins over timeout.
          if (!cnt_zero_s && fpu_ready) begin
            res_r   <= fpu_result;
            err_r   <= 1'b0;
            state_r <= ST_RESP;
          end else if (cnt_term_s) begin
            res_r   <= '0;
            err_r   <= 1'b1;
            state_r <= ST_RESP;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            if (err_r) begin
              err_count_r <= sat_inc8(err_count_r);
            end else begin
              ops_done_r  <= sat_inc16(ops_done_r);
            end
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = (state_r == ST_IDLE);
  assign busy          = (state_r != ST_IDLE);
  assign rsp_valid     = (state_r == ST_RESP);
  assign fpu_operand_1 = opa_r;
  assign fpu_operand_2 = opb_r;
  assign fpu_operation = op_r;
  assign rsp_result    = res_r;
  assign rsp_error     = err_r;
  assign ops_done      = ops_done_r;
  assign err_count     = err_count_r;

endmodule
